// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter.
//
// Contents:
//   state_e          - controller FSM state encoding
//   FunAdd..FunDiv   - arithmetic function codes carried in fun[1:0]
//   fun_has_carry()  - true for codes whose carry output is meaningful
//   fun_is_div()     - true for the divide code
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    localparam logic [1:0] FunAdd = 2'b00;
    localparam logic [1:0] FunSub = 2'b01;
    localparam logic [1:0] FunMul = 2'b10;
    localparam logic [1:0] FunDiv = 2'b11;

    function automatic logic fun_has_carry(input logic [3:0] fun);
        return (fun[1:0] == FunAdd) || (fun[1:0] == FunSub);
    endfunction

    function automatic logic fun_is_div(input logic [3:0] fun);
        return fun[1:0] == FunDiv;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin grant logic for the ALU arbiter.
//
// Searches the request vector starting at index ptr and wrapping from NUM_REQ-1 back to 0;
// the first set request found is granted. Purely combinational.
//
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   IdxW     index with highest priority this cycle
//   grant  out  NUM_REQ  one-hot grant, zero when no request is set
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic            found;
    logic [IdxW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IdxW'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ALU arbiter: shares one registered arithmetic unit among NUM_REQ requesters.
//
// A single command is in flight at a time. In IDLE the round-robin arbiter picks a
// requester, its operands are captured, driven to the ALU for one ISSUE cycle plus
// ALU_LATENCY WAIT cycles, and the ALU result is held as a response until consumed.
// A divide by zero bypasses the ALU and answers one cycle after accept.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid / req_ready     per-requester command handshake (ready is one-hot or zero)
//   req_a, req_b, req_fun     packed per-requester operands and function code
//   alu_a, alu_b, alu_fun     operands and function driven to the arithmetic unit
//   alu_enable                arithmetic unit enable (ISSUE and WAIT only)
//   alu_out, alu_carry        registered result and carry from the arithmetic unit
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    index of the requester owning the response
//   rsp_data, rsp_carry       result and carry (carry forced 0 for mul/div)
//   rsp_dz                    divide-by-zero flag
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ALU_LATENCY = 1,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]          req_fun,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    output logic [3:0]                    alu_fun,
    output logic                          alu_enable,
    input  logic [DATA_WIDTH-1:0]         alu_out,
    input  logic                          alu_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IdxW-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_carry,
    output logic                          rsp_dz
);

    localparam int unsigned CntW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    state_e state_q, state_d;

    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [3:0]            fun_q, fun_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_carry_q, rsp_carry_d;
    logic                  rsp_dz_q, rsp_dz_d;

    logic [NUM_REQ-1:0]    grant;
    logic [IdxW-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] a_sel;
    logic [DATA_WIDTH-1:0] b_sel;
    logic [3:0]            fun_sel;
    logic                  dz_sel;
    logic                  accept;
    logic                  wait_done;

    // ---------------------------------------------------------------------------------------
    // Arbitration and operand selection
    // ---------------------------------------------------------------------------------------
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        a_sel     = '0;
        b_sel     = '0;
        fun_sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IdxW'(i);
                a_sel     = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_sel     = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                fun_sel   = req_fun[i*4 +: 4];
            end
        end
    end

    assign dz_sel    = fun_is_div(fun_sel) && (b_sel == '0);
    assign accept    = |(req_valid & req_ready);
    assign wait_done = (cnt_q == CntW'(ALU_LATENCY - 1));

    // ---------------------------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = dz_sel ? StResp : StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (wait_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------------------------
    always_comb begin
        req_ready  = '0;
        alu_enable = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            // Reset holds the FSM in IDLE; gating with rst keeps ready low while it is asserted.
            StIdle:          req_ready  = rst ? grant : '0;
            StIssue, StWait: alu_enable = 1'b1;
            StResp:          rsp_valid  = 1'b1;
            default:         ;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------------------------
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        idx_d       = idx_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_dz_d    = rsp_dz_q;

        if (accept) begin
            rr_ptr_d = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            a_d      = a_sel;
            b_d      = b_sel;
            fun_d    = fun_sel;
            idx_d    = grant_idx;
            // Divide by zero is answered directly without touching the ALU.
            if (dz_sel) begin
                rsp_data_d  = '0;
                rsp_carry_d = 1'b0;
                rsp_dz_d    = 1'b1;
            end
        end

        if (state_q == StWait) begin
            if (wait_done) begin
                cnt_d       = '0;
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_carry & fun_has_carry(fun_q);
                rsp_dz_d    = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            idx_q       <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_dz_q    <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            idx_q       <= idx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_dz_q    <= rsp_dz_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_fun   = fun_q;
    assign rsp_id    = idx_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_dz    = rsp_dz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a reference model.
module tb_alu_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 1;
    localparam int unsigned IW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*4-1:0]  req_fun;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [3:0]      alu_fun;
    logic            alu_enable;
    logic [DW-1:0]   alu_out;
    logic            alu_carry;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_carry;
    logic            rsp_dz;

    logic [DW-1:0] a_arr [N];
    logic [DW-1:0] b_arr [N];
    logic [3:0]    f_arr [N];

    int n_cmp  = 0;
    int n_fail = 0;
    int en_cycles = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = a_arr[i];
            req_b[i*DW +: DW] = b_arr[i];
            req_fun[i*4 +: 4] = f_arr[i];
        end
    end

    alu_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (DW),
        .ALU_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_fun    (req_fun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fun    (alu_fun),
        .alu_enable (alu_enable),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_dz     (rsp_dz)
    );

    // Behavioural arithmetic unit: LAT-stage pipeline advancing while enabled.
    // Mul/div drive a non-zero carry on purpose so the response carry mask is exercised.
    function automatic logic [DW:0] alu_calc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] f);
        logic [DW-1:0] q;
        case (f[1:0])
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {a[0], DW'(a * b)};
            default: begin
                q = (b == '0) ? '1 : DW'($signed(a) / $signed(b));
                return {1'b1, q};
            end
        endcase
    endfunction

    logic [DW:0] pipe [LAT];
    always @(posedge clk) begin
        if (alu_enable) begin
            pipe[0] <= alu_calc(alu_a, alu_b, alu_fun);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign alu_out   = pipe[LAT-1][DW-1:0];
    assign alu_carry = pipe[LAT-1][DW];

    always @(negedge clk) if (alu_enable) en_cycles++;

    // ---------------------------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------------------------
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int idx = (p + i) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic ref_result(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [3:0] f, output logic [DW-1:0] d,
                              output logic c, output logic dz);
        int sa, sb, ua, ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        c  = 1'b0;
        dz = 1'b0;
        case (f[1:0])
            2'd0: begin d = DW'(sa + sb); c = (ua + ub) > 65535; end
            2'd1: begin d = DW'(sa - sb); c = ua < ub; end
            2'd2: d = DW'(sa * sb);
            default: begin
                if (sb == 0) begin d = '0; dz = 1'b1; end
                else d = DW'(sa / sb);
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic newcmd(input int i);
        a_arr[i] = DW'($urandom);
        if (a_arr[i] == 16'h8000) a_arr[i] = 16'h7fff;
        b_arr[i] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
        f_arr[i] = 4'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_alu_enable"}, 32'(alu_enable), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_carry"}, 32'(rsp_carry), 0);
        check({tag, "_rsp_dz"}, 32'(rsp_dz), 0);
        check({tag, "_alu_a"}, 32'(alu_a), 0);
    endtask

    // One full transaction from grant to response handshake; called at a negedge.
    task automatic serve(input int bp, input bit reload, output int got);
        int k, exp_id, en0, exp_lat;
        logic [DW-1:0] ed, ca, cb;
        logic [3:0] cf;
        logic ec, edz;
        got = -1;
        #1;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        exp_id = model_grant(req_valid, ptr_m);
        check("grant", 32'(req_ready), (exp_id < 0) ? 32'd0 : 32'(1 << exp_id));
        if (req_ready == '0 || exp_id < 0) return;
        for (int i = 0; i < N; i++) if (req_ready[i]) got = i;
        ca = a_arr[exp_id];
        cb = b_arr[exp_id];
        cf = f_arr[exp_id];
        ref_result(ca, cb, cf, ed, ec, edz);
        ptr_m   = (exp_id + 1) % N;
        exp_lat = edz ? 1 : LAT + 2;
        en0     = en_cycles;
        @(negedge clk);
        if (reload) newcmd(exp_id);
        else req_valid[exp_id] = 1'b0;
        k = 1;
        while (!rsp_valid && k < 20) begin
            check("busy_req_ready", 32'(req_ready), 0);
            if (alu_enable) begin
                check("alu_a", 32'(alu_a), 32'(ca));
                check("alu_b", 32'(alu_b), 32'(cb));
                check("alu_fun", 32'(alu_fun), 32'(cf));
            end
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(exp_lat));
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rsp_carry", 32'(rsp_carry), 32'(ec));
        check("rsp_dz", 32'(rsp_dz), 32'(edz));
        check("alu_en_cycles", 32'(en_cycles - en0), edz ? 32'd0 : 32'(LAT + 1));
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_ready", 32'(req_ready), 0);
            check("bp_id", 32'(rsp_id), 32'(exp_id));
            check("bp_data", 32'(rsp_data), 32'(ed));
            check("bp_dz", 32'(rsp_dz), 32'(edz));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_consumed", 32'(rsp_valid), 0);
    endtask

    // ---------------------------------------------------------------------------------------
    // Directed and random sequence
    // ---------------------------------------------------------------------------------------
    initial begin
        int got;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) newcmd(i);
        #2 rst = 1'b0;
        #1 check_all_zero("reset");

        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        ptr_m     = 0;
        @(negedge clk);

        // Single add from requester 2.
        a_arr[2] = 16'd5; b_arr[2] = 16'd3; f_arr[2] = 4'b0000;
        req_valid = 4'b0100;
        serve(0, 1'b0, got);
        check("single_id", 32'(got), 2);

        // Signed truncating divide from requester 1; search wraps 3 -> 0 -> 1.
        a_arr[1] = 16'hFFEC; b_arr[1] = 16'd3; f_arr[1] = 4'b0011;
        req_valid = 4'b0010;
        serve(0, 1'b0, got);
        check("div_id", 32'(got), 1);

        // Divide by zero from requester 0.
        a_arr[0] = 16'd7; b_arr[0] = 16'd0; f_arr[0] = 4'b0011;
        req_valid = 4'b0001;
        serve(0, 1'b0, got);
        check("dz_id", 32'(got), 0);

        // Backpressure on a multiply from requester 3.
        a_arr[3] = 16'd300; b_arr[3] = 16'hFFF9; f_arr[3] = 4'b0110;
        req_valid = 4'b1000;
        serve(5, 1'b0, got);
        check("bp_id", 32'(got), 3);

        // All four requesters continuously valid.
        for (int i = 0; i < N; i++) newcmd(i);
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            serve(t % 2, 1'b1, got);
            check("rr_order", 32'(got), 32'(exp_order[t]));
        end
        req_valid = '0;
        @(negedge clk);

        // Reset during WAIT discards the command.
        a_arr[0] = 16'd100; b_arr[0] = 16'd1; f_arr[0] = 4'b0000;
        req_valid = 4'b0001;
        #1 check("mid_grant", 32'(req_ready), 32'(1 << model_grant(req_valid, ptr_m)));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("mid_in_wait", 32'(alu_enable), 1);
        rst = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst   = 1'b1;
        ptr_m = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("no_rsp_after_reset", 32'(rsp_valid), 0);
            check("no_alu_after_reset", 32'(alu_enable), 0);
        end
        newcmd(1);
        newcmd(2);
        req_valid = 4'b0110;
        serve(0, 1'b0, got);
        check("post_reset_id", 32'(got), 1);
        serve(0, 1'b0, got);
        check("post_reset_id2", 32'(got), 2);

        // Random traffic: changing valid sets, random backpressure.
        for (int i = 0; i < N; i++) newcmd(i);
        for (int it = 0; it < 40; it++) begin
            req_valid = N'($urandom_range(1, 15));
            serve($urandom_range(0, 2), 1'b1, got);
        end
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one arithmetic unit.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16: operand and result width.
REQ-003 The block SHALL have parameter ALU_LATENCY, default 1: clk cycles from alu_enable asserted to alu_out valid.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester command valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 req_a, req_b  input  NUM_REQ*DATA_WIDTH  packed signed operands, requester i at slice i.
REQ-009 req_fun  input  NUM_REQ*4  packed function code; bits [1:0]: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 alu_a, alu_b  output  DATA_WIDTH  operands to arithmetic unit.
REQ-011 alu_fun  output  4  function code to arithmetic unit.
REQ-012 alu_enable  output  1  arithmetic unit enable.
REQ-013 alu_out  input  DATA_WIDTH  registered arithmetic result.
REQ-014 alu_carry  input  1  carry from arithmetic unit.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_ready  input  1  response consumer ready.
REQ-017 rsp_id  output  clog2(NUM_REQ)  index of requester owning the response.
REQ-018 rsp_data  output  DATA_WIDTH  result.
REQ-019 rsp_carry  output  1  carry, valid for add/sub only, else 0.
REQ-020 rsp_dz  output  1  divide-by-zero flag.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-022 In IDLE with any req_valid high, the block SHALL grant round-robin starting at pointer rr_ptr, assert req_ready for the granted index only in that cycle, and capture its a, b, fun and index.
REQ-023 A request SHALL be accepted only on a cycle where req_valid[i] and req_ready[i] are both high; req_ready SHALL be 0 in every state except IDLE.
REQ-024 On accept, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; with no accept, rr_ptr SHALL hold.
REQ-025 IDLE->ISSUE on accept; if the accepted fun[1:0]=11 and b=0, IDLE->RESP directly with rsp_data=0, rsp_dz=1, rsp_carry=0, and alu_enable never asserted.
REQ-026 In ISSUE and WAIT, alu_a, alu_b and alu_fun SHALL hold the captured values, and alu_enable SHALL be 1.
REQ-027 ISSUE SHALL last one cycle, then go to WAIT, where a counter SHALL run ALU_LATENCY cycles; on the last WAIT cycle, alu_out and alu_carry SHALL be captured into rsp_data and rsp_carry.
REQ-028 Accept-to-rsp_valid latency SHALL be exactly ALU_LATENCY+2 cycles for non-faulting commands, and 1 cycle for divide-by-zero.
REQ-029 In RESP, rsp_valid SHALL be 1 and rsp_id, rsp_data, rsp_carry and rsp_dz SHALL be stable until the cycle where rsp_ready=1; then the FSM SHALL go to IDLE.
REQ-030 Outside RESP, rsp_valid SHALL be 0; outside ISSUE/WAIT, alu_enable SHALL be 0.
REQ-031 Only one command SHALL be in flight at a time; no new grant is possible before the response handshake completes.
REQ-032 A requester deasserting req_valid before grant SHALL lose no state; the round-robin search SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-033 rst low SHALL asynchronously force state IDLE, rr_ptr=0, counter=0, captured registers=0, and req_ready, alu_enable, rsp_valid, rsp_data, rsp_id, rsp_carry and rsp_dz all 0.
REQ-034 Reset mid-operation SHALL discard the in-flight command with no response; the first grant after release SHALL start from index 0.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the function-code constants (ADD, SUB, MUL, DIV).
REQ-036 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req vector, pointer; output: one-hot grant).

Verification
REQ-037 Single request: requester 2 sends a=5, b=3, fun=00 -> rsp_id=2, rsp_data=8, rsp_carry=0, rsp_valid at accept+3.
REQ-038 All four requesters hold valid continuously -> grants in order 0,1,2,3,0; each is serviced once per 4 responses.
REQ-039 Divide by zero: a=7, b=0, fun=11 -> rsp_valid at accept+1, rsp_dz=1, rsp_data=0, alu_enable stays 0.
REQ-040 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready stays 0, response consumed on the first rsp_ready=1 cycle.
REQ-041 Reset pulse during WAIT -> all outputs 0 immediately, no response issued, next grant goes to the lowest-index valid requester.
REQ-042 Divide: a=-20, b=3, fun=11 -> rsp_data=-6 (truncating signed division), rsp_dz=0.
